// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Drains a byte FIFO onto a UART TX line (8N1 / 8N2, LSB
//                first). Pops one byte per frame with a single-cycle read
//                strobe, waits one cycle for the FIFO's registered data_out,
//                then emits start, eight data bits and STOP_BITS stop bits.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//    STOP_BITS    : number of stop bits (1 or 2)
//  Ports
//    clock      in   system clock, rising edge
//    reset      in   asynchronous active-low reset
//    enable     in   1 = may start new frames; 0 = finish frame, then idle
//    fifo_data  in   FIFO data_out, valid the cycle after fifo_read
//    fifo_empty in   FIFO empty flag
//    fifo_read  out  one-cycle pop strobe
//    tx         out  UART serial line, idle high
//    busy       out  high from the pop cycle through the last stop cycle
//    byte_done  out  one-cycle pulse in the final stop-bit cycle
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_read,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_baud_last    = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_baud_prelast = c_cnt_w'(CLKS_PER_BIT - 2);
    localparam logic [2:0]         c_stop_last    = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_FETCH = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_baud;
    logic [2:0]         r_bit_idx;  // data bit 0..7, reused as stop-bit index
    logic [7:0]         r_shift;

    // Every output is a register loaded with the value it must carry in the
    // state being entered, so tx/busy/fifo_read line up with the state
    // itself and nothing combinational reaches the pins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            fifo_read <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            fifo_read <= 1'b0;
            byte_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    // Only place enable/empty are looked at: once a pop is
                    // issued the frame always runs to completion.
                    if (enable && !fifo_empty) begin
                        r_state   <= S_READ;
                        fifo_read <= 1'b1;
                        busy      <= 1'b1;
                        r_baud    <= '0;
                    end
                end

                S_READ: begin
                    r_state <= S_FETCH;
                    r_baud  <= '0;
                end

                S_FETCH: begin
                    // FIFO output is registered: the popped byte is on
                    // fifo_data during this cycle.
                    r_shift <= fifo_data;
                    r_state <= S_START;
                    r_baud  <= '0;
                    tx      <= 1'b0;
                end

                S_START: begin
                    if (r_baud == c_baud_last) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        tx        <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_baud == c_baud_last) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            r_state   <= S_STOP;
                            tx        <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= r_shift >> 1;
                            tx        <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                S_STOP: begin
                    // Raised one cycle early so the registered pulse lands
                    // in the final stop-bit cycle.
                    if ((r_bit_idx == c_stop_last) && (r_baud == c_baud_prelast)) begin
                        byte_done <= 1'b1;
                    end
                    if (r_baud == c_baud_last) begin
                        r_baud <= '0;
                        if (r_bit_idx == c_stop_last) begin
                            r_bit_idx <= '0;
                            r_state   <= S_IDLE;
                            busy      <= 1'b0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_baud    <= '0;
                    r_bit_idx <= '0;
                    tx        <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Scoreboard bench for fifo_uart_tx. Two instances share the
//                clock: instance 0 with one stop bit, instance 1 with two.
//                Each has a queue-based FIFO model with a registered read.
//                Stimulus pushes expected frames; a negedge monitor decodes
//                the tx line and compares against the scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int CLKS = 4;
    localparam int SB0  = 1;
    localparam int SB1  = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0] reset_v  = 2'b00;
    logic [1:0] enable_v = 2'b00;
    logic [7:0] fdata0   = 8'h00;
    logic [7:0] fdata1   = 8'h00;
    logic       fempty0  = 1'b1;
    logic       fempty1  = 1'b1;
    wire  [1:0] rd_v;
    wire  [1:0] tx_v;
    wire  [1:0] busy_v;
    wire  [1:0] done_v;

    fifo_uart_tx #(.CLKS_PER_BIT(CLKS), .STOP_BITS(SB0)) u_dut0 (
        .clock(clock), .reset(reset_v[0]), .enable(enable_v[0]),
        .fifo_data(fdata0), .fifo_empty(fempty0), .fifo_read(rd_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .byte_done(done_v[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CLKS), .STOP_BITS(SB1)) u_dut1 (
        .clock(clock), .reset(reset_v[1]), .enable(enable_v[1]),
        .fifo_data(fdata1), .fifo_empty(fempty1), .fifo_read(rd_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .byte_done(done_v[1])
    );

    // ---------------- FIFO models (registered read) ----------------
    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    int underflow = 0;

    always @(posedge clock) begin
        if (rd_v[0]) begin
            if (fq0.size() == 0) underflow++;
            else fdata0 <= fq0.pop_front();
        end
        if (rd_v[1]) begin
            if (fq1.size() == 0) underflow++;
            else fdata1 <= fq1.pop_front();
        end
        fempty0 <= (fq0.size() == 0);
        fempty1 <= (fq1.size() == 0);
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] data;
        int         gap;       // idle cycles since previous frame, -1 = skip
        int         start_at;  // absolute start cycle, -1 = skip
    } exp_t;

    exp_t eq0[$];
    exp_t eq1[$];

    int vectors     = 0;
    int miscompares = 0;
    int stray_done  = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int         fcyc[2];
    int         start_c[2];
    int         end_c[2];
    int         read_c[2];
    int         reads[2];
    int         done_cnt[2];
    int         done_p[2];
    bit         in_frame[2];
    bit         wave_ok[2];
    bit         busy_ok[2];
    bit         post_chk[2];
    logic       cur_bit[2];
    logic [7:0] bits[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            fcyc[i] = 0; start_c[i] = 0; end_c[i] = 0; read_c[i] = 0;
            reads[i] = 0; done_cnt[i] = 0; done_p[i] = 0;
            in_frame[i] = 0; wave_ok[i] = 0; busy_ok[i] = 0;
            post_chk[i] = 0; cur_bit[i] = 1'b1; bits[i] = 8'h00;
        end
    end

    task automatic mon(input int i);
        int   frame_len;
        int   p;
        int   k;
        exp_t e;
        bit   have;
        logic t;
        frame_len = (9 + ((i == 0) ? SB0 : SB1)) * CLKS;
        t = tx_v[i];
        if (!reset_v[i]) begin
            in_frame[i] = 0;
            post_chk[i] = 0;
            return;
        end
        if (post_chk[i]) begin
            chk($sformatf("busy_low_after_frame_i%0d", i), int'(busy_v[i]), 0);
            post_chk[i] = 0;
        end
        if (rd_v[i]) begin
            reads[i]++;
            read_c[i] = cyc;
        end
        if (!in_frame[i]) begin
            if (done_v[i]) stray_done++;
            if (t != 1'b0) return;
            in_frame[i] = 1;
            fcyc[i]     = 0;
            start_c[i]  = cyc;
            bits[i]     = 8'h00;
            wave_ok[i]  = 1;
            busy_ok[i]  = 1;
            done_cnt[i] = 0;
            done_p[i]   = -1;
        end
        p = fcyc[i];
        if (!busy_v[i]) busy_ok[i] = 0;
        if (done_v[i]) begin
            done_cnt[i]++;
            done_p[i] = p;
        end
        if (p < CLKS) begin
            if (t != 1'b0) wave_ok[i] = 0;
        end else if (p < 9 * CLKS) begin
            k = (p - CLKS) / CLKS;
            if ((p - CLKS) % CLKS == 0) begin
                cur_bit[i]    = t;
                bits[i][k]    = t;
            end else if (t != cur_bit[i]) begin
                wave_ok[i] = 0;
            end
        end else if (t != 1'b1) begin
            wave_ok[i] = 0;
        end

        if (p == frame_len - 1) begin
            in_frame[i] = 0;
            post_chk[i] = 1;
            have = 0;
            if (i == 0 && eq0.size() > 0) begin e = eq0.pop_front(); have = 1; end
            if (i == 1 && eq1.size() > 0) begin e = eq1.pop_front(); have = 1; end
            chk($sformatf("frame_expected_i%0d", i), int'(have), 1);
            if (have) begin
                chk($sformatf("data_i%0d", i), int'(bits[i]), int'(e.data));
                chk($sformatf("waveform_i%0d", i), int'(wave_ok[i]), 1);
                chk($sformatf("byte_done_count_i%0d", i), done_cnt[i], 1);
                chk($sformatf("byte_done_pos_i%0d", i), done_p[i], frame_len - 1);
                chk($sformatf("busy_in_frame_i%0d", i), int'(busy_ok[i]), 1);
                chk($sformatf("read_to_start_i%0d", i), start_c[i] - read_c[i], 2);
                if (e.gap >= 0)
                    chk($sformatf("idle_gap_i%0d", i), start_c[i] - end_c[i] - 1, e.gap);
                if (e.start_at >= 0)
                    chk($sformatf("start_cycle_i%0d", i), start_c[i], e.start_at);
            end
            end_c[i] = cyc;
        end else begin
            fcyc[i] = p + 1;
        end
    endtask

    always @(negedge clock) begin
        mon(0);
        mon(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic fpush(input int i, input logic [7:0] d);
        if (i == 0) fq0.push_back(d);
        else        fq1.push_back(d);
    endtask

    task automatic expect_frame(input int i, input logic [7:0] d, input int gap, input int start_at);
        exp_t e;
        e.data = d;
        e.gap = gap;
        e.start_at = start_at;
        if (i == 0) eq0.push_back(e);
        else        eq1.push_back(e);
    endtask

    task automatic wait_drain(input int i, input int budget, input string name);
        bit ok;
        int qs;
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            qs = (i == 0) ? eq0.size() : eq1.size();
            if (qs == 0 && !in_frame[i] && !post_chk[i] && tx_v[i] == 1'b1) begin
                ok = 1;
                break;
            end
            tick(1);
        end
        chk(name, int'(ok), 1);
    endtask

    task automatic wait_data_pos(input int i, input int pos, input string name);
        bit ok;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            if (in_frame[i] && fcyc[i] >= pos) begin
                ok = 1;
                break;
            end
            tick(1);
        end
        chk(name, int'(ok), 1);
    endtask

    // ---------------- stimulus ----------------
    int r;
    int lows;

    initial begin
        // Reset
        reset_v  = 2'b00;
        enable_v = 2'b00;
        tick(3);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_tx_i%0d", i), int'(tx_v[i]), 1);
            chk($sformatf("reset_fifo_read_i%0d", i), int'(rd_v[i]), 0);
            chk($sformatf("reset_busy_i%0d", i), int'(busy_v[i]), 0);
            chk($sformatf("reset_byte_done_i%0d", i), int'(done_v[i]), 0);
        end
        reset_v = 2'b11;
        tick(2);

        // Single byte 0xA5
        fpush(0, 8'hA5);
        expect_frame(0, 8'hA5, -1, -1);
        enable_v[0] = 1'b1;
        wait_drain(0, 200, "drain_single");
        chk("single_pop_count", reads[0], 1);

        // Back-to-back 0x01, 0x80, 0xFF
        enable_v[0] = 1'b0;
        fpush(0, 8'h01);
        fpush(0, 8'h80);
        fpush(0, 8'hFF);
        expect_frame(0, 8'h01, -1, -1);
        expect_frame(0, 8'h80, 3, -1);
        expect_frame(0, 8'hFF, 3, -1);
        tick(2);
        enable_v[0] = 1'b1;
        wait_drain(0, 400, "drain_b2b");
        chk("b2b_pop_count", reads[0], 4);
        chk("b2b_fifo_left", fq0.size(), 0);
        chk("b2b_fifo_empty", int'(fempty0), 1);

        // Empty with enable, then data with enable low
        r = reads[0];
        lows = 0;
        for (int n = 0; n < 100; n++) begin
            if (tx_v[0] == 1'b0) lows++;
            tick(1);
        end
        chk("empty_no_pop", reads[0], r);
        chk("empty_tx_high", lows, 0);
        enable_v[0] = 1'b0;
        fpush(0, 8'h5A);
        for (int n = 0; n < 100; n++) begin
            if (tx_v[0] == 1'b0) lows++;
            tick(1);
        end
        chk("disabled_no_pop", reads[0], r);
        chk("disabled_tx_high", lows, 0);
        expect_frame(0, 8'h5A, -1, cyc + 3);
        enable_v[0] = 1'b1;
        wait_drain(0, 200, "drain_after_enable");
        chk("enable_pop_count", reads[0], r + 1);

        // Enable drop during data bit 3
        enable_v[0] = 1'b0;
        fpush(0, 8'h3A);
        fpush(0, 8'hC4);
        expect_frame(0, 8'h3A, -1, -1);
        tick(2);
        enable_v[0] = 1'b1;
        wait_data_pos(0, 4 + 3 * CLKS + 1, "reach_bit3");
        enable_v[0] = 1'b0;
        r = reads[0];
        wait_drain(0, 200, "drain_enable_drop");
        tick(20);
        chk("enable_drop_no_second_pop", reads[0], r);
        chk("enable_drop_tx_idle", int'(tx_v[0]), 1);
        chk("enable_drop_fifo_left", fq0.size(), 1);
        expect_frame(0, 8'hC4, -1, cyc + 3);
        enable_v[0] = 1'b1;
        wait_drain(0, 200, "drain_reenable");
        chk("reenable_pop_count", reads[0], r + 1);

        // Reset mid-frame on the two-stop-bit instance
        fpush(1, 8'h96);
        enable_v[1] = 1'b1;
        wait_data_pos(1, 10, "reach_mid_frame");
        reset_v[1] = 1'b0;
        #1;
        chk("midreset_tx_high", int'(tx_v[1]), 1);
        chk("midreset_busy_low", int'(busy_v[1]), 0);
        tick(3);
        chk("midreset_hold_tx", int'(tx_v[1]), 1);
        chk("midreset_hold_read", int'(rd_v[1]), 0);
        reset_v[1] = 1'b1;
        tick(5);
        chk("midreset_pop_count", reads[1], 1);
        chk("midreset_tx_idle", int'(tx_v[1]), 1);
        fpush(1, 8'h3C);
        expect_frame(1, 8'h3C, -1, -1);
        wait_drain(1, 300, "drain_two_stop");
        chk("two_stop_pop_count", reads[1], 2);

        // Global checks
        tick(2);
        chk("fifo_underflow", underflow, 0);
        chk("stray_byte_done", stray_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
